// File: rtl/nios2_mul_share_arbiter.sv
// Round-robin share of one 32x32->32 multiplier cell between two requesters; result pulse LATENCY+2 cycles after accept.
// Requesters are back-pressured only by losing arbitration; results cannot stall and must be sunk in their pulse cycle.
module nios2_mul_share_arbiter #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_src1,
  input  logic [31:0] r0_src2,
  output logic        r0_result_valid,
  output logic [31:0] r0_result,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_src1,
  input  logic [31:0] r1_src2,
  output logic        r1_result_valid,
  output logic [31:0] r1_result,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  input  logic [31:0] cell_result,
  output logic        idle
);

  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic               xfer;
  logic [LATENCY:0]   tag_vld;
  logic [LATENCY:0]   tag_id;
  logic               out_vld;
  logic               out_id;

  // last_grant holds the ID of the most recent winner; the other side wins a tie.
  always_comb begin
    grant0 = r0_valid && (!r1_valid || last_grant);
    grant1 = r1_valid && (!r0_valid || !last_grant);
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign xfer     = grant0 || grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      cell_src1  <= '0;
      cell_src2  <= '0;
    end else if (xfer) begin
      last_grant <= grant1;
      cell_src1  <= grant1 ? r1_src1 : r0_src1;
      cell_src2  <= grant1 ? r1_src2 : r0_src2;
    end
  end

  // Stage k of the tag pipeline lines up with cell operands that entered k cycles ago.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[LATENCY-1:0], xfer};
      tag_id  <= {tag_id[LATENCY-1:0], grant1};
    end
  end

  assign out_vld = tag_vld[LATENCY];
  assign out_id  = tag_id[LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_result_valid <= 1'b0;
      r1_result_valid <= 1'b0;
      r0_result       <= '0;
      r1_result       <= '0;
    end else begin
      r0_result_valid <= out_vld && !out_id;
      r1_result_valid <= out_vld && out_id;
      if (out_vld && !out_id) r0_result <= cell_result;
      if (out_vld && out_id)  r1_result <= cell_result;
    end
  end

  assign idle = !(|tag_vld) && !r0_result_valid && !r1_result_valid;

endmodule
